// File: rtl/calc_if.sv
// Keypad/display-side bundle of the calc_sequencer: operand entry, strobes, result and flags.
interface calc_if #(
  parameter int WIDTH = 8
);
  logic             button;
  logic             clear;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             show_result;
  logic             clear_input;
  logic             busy;
  logic             overflow;
  logic             error;

  modport master (
    output button, clear, op, operand,
    input  result, show_result, clear_input, busy, overflow, error
  );

  modport slave (
    input  button, clear, op, operand,
    output result, show_result, clear_input, busy, overflow, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Operand-sequencing calculator core: ENTER_A -> ENTER_B -> EXEC -> SHOW with a restoring divider.
// Optional result chaining (SHOW edge loads A from R, goes to ENTER_B) is enabled by CALC_CHAIN_EN.
module calc_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  calc_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_t;

  state_t             state, state_next;
  logic               btn_q;
  logic               btn_edge;
  logic [WIDTH-1:0]   a_q, b_q, r_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   rem_q, quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               show_q, clear_input_q, busy_q, overflow_q, error_q;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic               is_div, div_zero, exec_done;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_ovf, alu_err;

  assign btn_edge = bus.button & ~btn_q;

  // One restoring-division step: shift next dividend bit in, subtract B if it fits.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign fits      = ~rem_diff[WIDTH];
  assign rem_step  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], fits};

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  assign is_div    = (op_q == 3'b011) || (op_q == 3'b100);
  assign div_zero  = is_div && (b_q == '0);
  assign exec_done = (state == EXEC) &&
                     (!is_div || div_zero || (cnt_q == CNT_W'(WIDTH - 1)));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_r   = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    unique case (op_q)
      3'b000: begin alu_r = sum[WIDTH-1:0];  alu_ovf = sum[WIDTH];  end
      3'b001: begin alu_r = diff[WIDTH-1:0]; alu_ovf = diff[WIDTH]; end
      3'b010: begin alu_r = prod[WIDTH-1:0]; alu_ovf = |prod[2*WIDTH-1:WIDTH]; end
      3'b011: begin alu_r = div_zero ? '1  : quo_step; alu_err = div_zero; end
      3'b100: begin alu_r = div_zero ? a_q : rem_step; alu_err = div_zero; end
      3'b101: alu_r = a_q & b_q;
      3'b110: alu_r = a_q | b_q;
      default: alu_r = a_q ^ b_q;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ENTER_A: if (btn_edge) state_next = ENTER_B;
      ENTER_B: if (btn_edge) state_next = EXEC;
      EXEC:    if (exec_done) state_next = SHOW;
      SHOW: begin
        if (btn_edge) begin
`ifdef CALC_CHAIN_EN
          state_next = ENTER_B;
`else
          state_next = ENTER_A;
`endif
        end
      end
      default: state_next = ENTER_A;
    endcase
    if (bus.clear) state_next = ENTER_A;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ENTER_A;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q         <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      r_q           <= '0;
      op_q          <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      show_q        <= 1'b0;
      clear_input_q <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
    end else if (bus.clear) begin
      btn_q         <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      r_q           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      show_q        <= 1'b0;
      clear_input_q <= 1'b1;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      btn_q         <= bus.button;
      clear_input_q <= 1'b0;
      show_q        <= (state_next == SHOW);
      busy_q        <= (state_next == EXEC);
      unique case (state)
        ENTER_A: begin
          if (btn_edge) begin
            a_q           <= bus.operand;
            clear_input_q <= 1'b1;
          end
        end
        ENTER_B: begin
          if (btn_edge) begin
            b_q           <= bus.operand;
            op_q          <= bus.op;
            clear_input_q <= 1'b1;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
            rem_q         <= '0;
            quo_q         <= a_q;
            cnt_q         <= '0;
          end
        end
        EXEC: begin
          if (exec_done) begin
            r_q        <= alu_r;
            overflow_q <= alu_ovf;
            error_q    <= alu_err;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (btn_edge) begin
            clear_input_q <= 1'b1;
`ifdef CALC_CHAIN_EN
            a_q           <= r_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result      = r_q;
  assign bus.show_result = show_q;
  assign bus.clear_input = clear_input_q;
  assign bus.busy        = busy_q;
  assign bus.overflow    = overflow_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes model results, a negedge monitor pops and compares.
module tb_calc_sequencer;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  typedef struct {
    int r;
    int ovf;
    int err;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  bit   chain_pending = 1'b0;
  int   last_r = 0;
  int   busy_run = 0;
  bit   show_prev = 1'b0;

  calc_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model straight from the operation table, in plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int   full;
    e.ovf = 0;
    e.err = 0;
    e.lat = 1;
    case (op)
      0: begin full = a + b; e.r = full & MASK; e.ovf = (full > MASK) ? 1 : 0; end
      1: begin e.r = (a - b) & MASK; e.ovf = (a < b) ? 1 : 0; end
      2: begin full = a * b; e.r = full & MASK; e.ovf = (full > MASK) ? 1 : 0; end
      3: begin
        if (b == 0) begin e.r = MASK; e.err = 1; end
        else begin e.r = a / b; e.lat = W; end
      end
      4: begin
        if (b == 0) begin e.r = a; e.err = 1; end
        else begin e.r = a % b; e.lat = W; end
      end
      5: e.r = a & b;
      6: e.r = a | b;
      default: e.r = a ^ b;
    endcase
    return e;
  endfunction

  // Called at a negedge; presses the key for one cycle and checks the one-cycle clear_input pulse.
  task automatic press(input int val, input int op);
    bus.operand = val[W-1:0];
    bus.op      = op[2:0];
    bus.button  = 1'b1;
    @(negedge clk);
    check("clear_input pulse", bus.clear_input, 1);
    bus.button = 1'b0;
    @(negedge clk);
    check("clear_input width", bus.clear_input, 0);
  endtask

  task automatic wait_show();
    for (int i = 0; i < 64 && !bus.show_result; i++) @(negedge clk);
    check("show_result reached", bus.show_result, 1);
  endtask

  task automatic do_op(input int a, input int b, input int op);
    exp_t e;
    int   ea;
    if (chain_pending) ea = last_r;
    else begin
      ea = a;
      press(a, 0);
    end
    e = model(ea, b, op);
    sb_q.push_back(e);
    press(b, op);
    wait_show();
    last_r = e.r;
    press(0, 0);
    check("show_result dropped", bus.show_result, 0);
    chain_pending = CHAIN;
  endtask

  // Monitor: counts busy cycles and scores each result the moment SHOW is entered.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_run  = 0;
      show_prev = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.show_result && !show_prev) begin
        if (sb_q.size() == 0) check("scoreboard underflow", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          check("result", bus.result, e.r);
          check("overflow", bus.overflow, e.ovf);
          check("error", bus.error, e.err);
          check("busy cycles", busy_run, e.lat);
        end
      end
      if (!bus.busy && !bus.show_result) busy_run = 0;
      show_prev = bus.show_result;
    end
  end

  initial begin
    reset       = 1'b1;
    bus.button  = 1'b0;
    bus.clear   = 1'b0;
    bus.op      = '0;
    bus.operand = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset result", bus.result, 0);
    check("reset show_result", bus.show_result, 0);
    check("reset clear_input", bus.clear_input, 0);
    check("reset busy", bus.busy, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset error", bus.error, 0);

    do_op(25, 17, 0);
    do_op(200, 100, 0);
    do_op(15, 20, 2);
    do_op(12, 10, 2);
    do_op(100, 7, 3);
    do_op(100, 7, 4);
    do_op(9, 0, 3);
    do_op(9, 0, 4);
    do_op(3, 200, 1);
    do_op(255, 255, 4);

    // Chained pair: with chaining the second A is the previous result (8), otherwise entered as 8.
    do_op(5, 3, 0);
    do_op(8, 2, 2);

    // Clear during the 4th EXEC cycle of a divide aborts everything.
    if (!chain_pending) press(100, 0);
    press(7, 3);
    @(negedge clk);
    @(negedge clk);
    check("busy before clear", bus.busy, 1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("clear busy", bus.busy, 0);
    check("clear result", bus.result, 0);
    check("clear clear_input", bus.clear_input, 1);
    check("clear show_result", bus.show_result, 0);
    check("clear error", bus.error, 0);
    @(negedge clk);
    check("clear pulse width", bus.clear_input, 0);
    chain_pending = 1'b0;
    do_op(77, 11, 3);

    // Button held through reset must not register an edge until re-pressed.
    bus.button = 1'b1;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held button no edge", bus.clear_input, 0);
    end
    bus.button = 1'b0;
    @(negedge clk);
    chain_pending = 1'b0;
    do_op(40, 2, 2);

    for (int i = 0; i < 40; i++) begin
      int a, b, op;
      a  = $urandom_range(0, MASK);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      op = $urandom_range(0, 7);
      do_op(a, b, op);
    end

    repeat (2) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
